// File: rtl/la_orn_sticky.sv
// la_orn_sticky: sticky per-channel event capture with masked OR-reduction
// and a lowest-index priority encoder for interrupt/status aggregation.

// One channel: event detect (level or rising edge) and its sticky pending flag.
module la_orn_sticky_lane #(
    parameter int EDGE = 0
) (
    input  logic clk,
    input  logic nreset,
    input  logic in_bit,
    input  logic clr_bit,
    output logic pend_bit
);
    logic evt;

    generate
        if (EDGE != 0) begin : g_edge
            logic in_q;
            // Previous input sample; reset to 0 so an input already high
            // at release counts as a rising edge.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) in_q <= 1'b0;
                else         in_q <= in_bit;
            end
            assign evt = in_bit & ~in_q;
        end else begin : g_level
            assign evt = in_bit;
        end
    endgenerate

    // Sticky flag: a clear never wins against an event in the same cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) pend_bit <= 1'b0;
        else         pend_bit <= (pend_bit & ~clr_bit) | evt;
    end
endmodule

module la_orn_sticky #(
    parameter int N      = 8,
    parameter int EDGE   = 0,
    parameter int OUTREG = 1,
    parameter     PROP   = "DEFAULT",
    localparam int IW    = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [N-1:0]  in,
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  clr,
    output logic [N-1:0]  pend,
    output logic          z,
    output logic [IW-1:0] id
);
    logic [N-1:0]  act;
    logic          act_z;
    logic [IW-1:0] act_id;

    la_orn_sticky_lane #(.EDGE(EDGE)) u_lane [N-1:0] (
        .clk      (clk),
        .nreset   (nreset),
        .in_bit   (in),
        .clr_bit  (clr),
        .pend_bit (pend)
    );

    assign act = pend & ~mask;

    // Lowest set index wins: scan downward so the last hit is the lowest.
    // Encoder codes above N-1 are simply never produced.
    always_comb begin
        act_z  = |act;
        act_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i]) act_id = IW'(i);
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            // Registered reduction: z/id lag pend/mask by one edge.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    z  <= 1'b0;
                    id <= '0;
                end else begin
                    z  <= act_z;
                    id <= act_id;
                end
            end
        end else begin : g_ocomb
            assign z  = act_z;
            assign id = act_id;
        end
    endgenerate
endmodule

// File: tb/tb_la_orn_sticky.sv
// Bench for la_orn_sticky: three instances (level/registered, edge/registered,
// level/combinational) sharing stimulus; expectations queued per edge.
module tb_la_orn_sticky;
    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] tin, mask, clr;
    logic [7:0] pend_l1, pend_e1, pend_l0;
    logic       z_l1, z_e1, z_l0;
    logic [2:0] id_l1, id_e1, id_l0;

    typedef struct {
        logic [7:0] pend;
        logic       z;
        logic [2:0] id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    la_orn_sticky #(.N(8), .EDGE(0), .OUTREG(1)) u_l1 (
        .clk(clk), .nreset(nreset), .in(tin), .mask(mask), .clr(clr),
        .pend(pend_l1), .z(z_l1), .id(id_l1));
    la_orn_sticky #(.N(8), .EDGE(1), .OUTREG(1)) u_e1 (
        .clk(clk), .nreset(nreset), .in(tin), .mask(mask), .clr(clr),
        .pend(pend_e1), .z(z_e1), .id(id_e1));
    la_orn_sticky #(.N(8), .EDGE(0), .OUTREG(0)) u_l0 (
        .clk(clk), .nreset(nreset), .in(tin), .mask(mask), .clr(clr),
        .pend(pend_l0), .z(z_l0), .id(id_l0));

    task automatic do_reset();
        tin = 8'h00; mask = 8'h00; clr = 8'h00; nreset = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        tin = 8'hFF; mask = 8'h00; clr = 8'h00; nreset = 1'b0;
        #3;
        checks++; if (pend_e1 !== 8'h00 || pend_l1 !== 8'h00 || pend_l0 !== 8'h00) begin
            failures++; $display("FAIL rst_pend: got %h/%h/%h want 00", pend_l1, pend_e1, pend_l0); end
        checks++; if ({z_l1, z_e1, z_l0} !== 3'b000 || {id_l1, id_e1, id_l0} !== 9'd0) begin
            failures++; $display("FAIL rst_zid: got z=%b%b%b id=%0d/%0d/%0d want 0", z_l1, z_e1, z_l0, id_l1, id_e1, id_l0); end
        @(posedge clk); #1;
        checks++; if (pend_e1 !== 8'h00) begin
            failures++; $display("FAIL rst_held: got %h want 00", pend_e1); end
        nreset = 1'b1;
        exp_q.push_back('{pend: 8'hFF, z: 1'b0, id: 3'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (pend_e1 !== e.pend || z_e1 !== e.z) begin
            failures++; $display("FAIL rst_edge_first: got pend=%h z=%b want pend=%h z=%b", pend_e1, z_e1, e.pend, e.z); end
        checks++; if (pend_l1 !== 8'hFF || z_l0 !== 1'b1 || id_l0 !== 3'd0) begin
            failures++; $display("FAIL rst_level_first: got pend=%h z0=%b id0=%0d want FF 1 0", pend_l1, z_l0, id_l0); end
        exp_q.push_back('{pend: 8'hFF, z: 1'b1, id: 3'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (z_e1 !== e.z || id_e1 !== e.id || pend_e1 !== e.pend) begin
            failures++; $display("FAIL rst_edge_z: got z=%b id=%0d pend=%h want z=%b id=%0d pend=%h", z_e1, id_e1, pend_e1, e.z, e.id, e.pend); end
        // Held-high input with clear: edge mode stays clear, level re-sets.
        clr = 8'hFF;
        @(posedge clk); #1;
        clr = 8'h00;
        @(posedge clk); #1;
        checks++; if (pend_e1 !== 8'h00 || pend_l1 !== 8'hFF) begin
            failures++; $display("FAIL rst_held_clr: got e=%h l=%h want 00 FF", pend_e1, pend_l1); end
        tin = 8'h00;
    endtask

    task automatic test_level();
        do_reset();
        tin = 8'h20;
        exp_q.push_back('{pend: 8'h20, z: 1'b0, id: 3'd0});
        exp_q.push_back('{pend: 8'h20, z: 1'b1, id: 3'd5});
        exp_q.push_back('{pend: 8'h20, z: 1'b1, id: 3'd5});
        exp_q.push_back('{pend: 8'h00, z: 1'b1, id: 3'd5});
        exp_q.push_back('{pend: 8'h00, z: 1'b0, id: 3'd0});
        for (int c = 0; c < 5; c++) begin
            clr = (c == 3) ? 8'h20 : 8'h00;
            @(posedge clk); #1;
            tin = 8'h00;
            e = exp_q.pop_front();
            checks++; if (pend_l1 !== e.pend || z_l1 !== e.z || id_l1 !== e.id) begin
                failures++; $display("FAIL level_c%0d: got pend=%h z=%b id=%0d want pend=%h z=%b id=%0d",
                                     c, pend_l1, z_l1, id_l1, e.pend, e.z, e.id); end
            if (c == 0) begin
                checks++; if (z_l0 !== 1'b1 || id_l0 !== 3'd5) begin
                    failures++; $display("FAIL level_comb: got z=%b id=%0d want 1 5", z_l0, id_l0); end
            end
        end
        clr = 8'h00;
    endtask

    task automatic test_edge();
        do_reset();
        tin = 8'h08;
        for (int c = 0; c < 10; c++) begin
            clr = (c == 4) ? 8'h08 : 8'h00;
            exp_q.push_back('{pend: (c < 4) ? 8'h08 : 8'h00, z: 1'b0, id: 3'd0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (pend_e1 !== e.pend) begin
                failures++; $display("FAIL edge_hold_c%0d: got %h want %h", c, pend_e1, e.pend); end
            if (c == 4) begin
                checks++; if (pend_l1 !== 8'h08) begin
                    failures++; $display("FAIL edge_level_held: got %h want 08", pend_l1); end
            end
        end
        clr = 8'h00; tin = 8'h00;
        exp_q.push_back('{pend: 8'h00, z: 1'b0, id: 3'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (pend_e1 !== e.pend) begin
            failures++; $display("FAIL edge_drop: got %h want %h", pend_e1, e.pend); end
        tin = 8'h08;
        exp_q.push_back('{pend: 8'h08, z: 1'b0, id: 3'd0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (pend_e1 !== e.pend) begin
            failures++; $display("FAIL edge_reraise: got %h want %h", pend_e1, e.pend); end
        tin = 8'h00;
    endtask

    task automatic test_set_beats_clr();
        logic [7:0] l_exp [4] = '{8'h02, 8'h02, 8'h02, 8'h02};
        logic [7:0] e_exp [4] = '{8'h02, 8'h00, 8'h00, 8'h02};
        logic [7:0] in_s  [4] = '{8'h02, 8'h02, 8'h00, 8'h02};
        logic [7:0] clr_s [4] = '{8'h00, 8'h02, 8'h00, 8'h02};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tin = in_s[c]; clr = clr_s[c];
            exp_q.push_back('{pend: l_exp[c], z: 1'b0, id: 3'd0});
            exp_q.push_back('{pend: e_exp[c], z: 1'b0, id: 3'd0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (pend_l1 !== e.pend) begin
                failures++; $display("FAIL setclr_level_c%0d: got %h want %h", c, pend_l1, e.pend); end
            e = exp_q.pop_front();
            checks++; if (pend_e1 !== e.pend) begin
                failures++; $display("FAIL setclr_edge_c%0d: got %h want %h", c, pend_e1, e.pend); end
        end
        tin = 8'h00; clr = 8'h00;
    endtask

    task automatic test_mask_priority();
        logic [7:0] m_s [4] = '{8'h04, 8'h14, 8'h94, 8'h00};
        logic       z_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] i_s [4] = '{3'd4, 3'd7, 3'd0, 3'd2};
        do_reset();
        tin = 8'h94;
        @(posedge clk); #1;
        tin = 8'h00;
        for (int c = 0; c < 4; c++) begin
            mask = m_s[c];
            exp_q.push_back('{pend: 8'h94, z: z_s[c], id: i_s[c]});
            #1;
            checks++; if (z_l0 !== z_s[c] || id_l0 !== i_s[c]) begin
                failures++; $display("FAIL mask_comb_%h: got z=%b id=%0d want z=%b id=%0d", m_s[c], z_l0, id_l0, z_s[c], i_s[c]); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (pend_l1 !== e.pend || z_l1 !== e.z || id_l1 !== e.id) begin
                failures++; $display("FAIL mask_reg_%h: got pend=%h z=%b id=%0d want pend=%h z=%b id=%0d",
                                     m_s[c], pend_l1, z_l1, id_l1, e.pend, e.z, e.id); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tin = 8'hFF;
        @(posedge clk); #1;
        tin = 8'h00;
        @(posedge clk); #1;
        checks++; if (pend_l1 !== 8'hFF || z_l1 !== 1'b1) begin
            failures++; $display("FAIL midrst_pre: got pend=%h z=%b want FF 1", pend_l1, z_l1); end
        #2;
        nreset = 1'b0;
        #1;
        checks++; if ({pend_l1, pend_e1, pend_l0} !== 24'h0 || {z_l1, z_e1, z_l0} !== 3'b0 ||
                      {id_l1, id_e1, id_l0} !== 9'd0) begin
            failures++; $display("FAIL midrst: got pend=%h/%h/%h z=%b%b%b id=%0d want all 0",
                                 pend_l1, pend_e1, pend_l0, z_l1, z_e1, z_l0, id_l1); end
        @(posedge clk); #1;
        nreset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_set_beats_clr();
        test_mask_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
